decrypt_sequencer: RTL and testbench

DECRYPT_SEQUENCER -- requirements
Module: decrypt_sequencer

---
 rtl/decrypt_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_decrypt_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_sequencer.sv
// Sequences a 12-byte key load and single-outstanding decrypt requests toward an external decryptor.
// Latency: key load 12 cycles after key_start; result one cycle after the decryptor answers or TIMEOUT cycles after issue.
// Backpressure: in_ready drops while a key load or request is pending; results are held on out_* until out_ready.
module decrypt_sequencer #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,

    // key load request
    input  logic        key_start,
    input  logic [95:0] key_in,
    output logic        key_busy,
    output logic        key_loaded,

    // ciphertext pair input
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_ct,
    input  logic        in_upper,

    // plaintext result output
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pt,
    output logic [2:0]  out_err,
    output logic [15:0] pt_count,

    // decryptor key port
    output logic [7:0]  dec_key_byte,
    output logic [3:0]  dec_byte_pos,
    output logic        dec_key_byte_val,

    // decryptor request port
    output logic        dec_ctxt_valid,
    output logic [15:0] dec_ciphertext,
    output logic        dec_upper_lower,

    // decryptor response port
    input  logic [7:0]  dec_plaintext,
    input  logic        dec_ptxt_ready,
    input  logic        dec_err_key,
    input  logic        dec_err_ct
);

    // Wide enough to hold TIMEOUT itself, so TIMEOUT-1 always fits.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [95:0]     key_q;
    logic [3:0]      byte_idx;
    logic [3:0]      byte_idx_inc;
    logic [TW-1:0]   wait_cnt;

    logic            req_go;
    logic            key_go;
    logic            load_last;
    logic            rsp_hit;
    logic            tmo_hit;
    logic            out_fire;
    logic            rsp_err;

    // Event decode shared by the next-state and output processes.
    // A ciphertext handshake wins over a same-cycle key_start in READY so an
    // accepted pair is never silently discarded.
    always_comb begin
        req_go       = (state == S_READY) && in_valid && in_ready;
        key_go       = key_start && ((state == S_IDLE) || ((state == S_READY) && !req_go));
        load_last    = (state == S_LOAD) && (byte_idx == LAST_BYTE);
        rsp_hit      = (state == S_WAIT) && (dec_ptxt_ready || dec_err_key || dec_err_ct);
        tmo_hit      = (state == S_WAIT) && !rsp_hit && (wait_cnt == WAIT_LAST);
        out_fire     = (state == S_OUT) && out_valid && out_ready;
        rsp_err      = dec_err_key || dec_err_ct;
        byte_idx_inc = byte_idx + 4'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (key_go) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_last) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (req_go) begin
                    state_nxt = S_WAIT;
                end else if (key_go) begin
                    state_nxt = S_LOAD;
                end
            end
            S_WAIT: begin
                if (rsp_hit || tmo_hit) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    // A key rejected by the decryptor forces a reload.
                    state_nxt = out_err[0] ? S_IDLE : S_READY;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs plus the key shadow, byte index and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q            <= '0;
            byte_idx         <= '0;
            wait_cnt         <= '0;
            key_busy         <= 1'b0;
            key_loaded       <= 1'b0;
            in_ready         <= 1'b0;
            out_valid        <= 1'b0;
            out_pt           <= '0;
            out_err          <= '0;
            pt_count         <= '0;
            dec_key_byte     <= '0;
            dec_byte_pos     <= '0;
            dec_key_byte_val <= 1'b0;
            dec_ctxt_valid   <= 1'b0;
            dec_ciphertext   <= '0;
            dec_upper_lower  <= 1'b0;
        end else begin
            // Only READY can accept a pair; this keeps one request outstanding.
            in_ready <= (state_nxt == S_READY);

            // Key load: byte 0 is presented on the cycle after key_start,
            // then one byte per cycle up to position 11.
            if (key_go) begin
                key_q            <= key_in;
                key_loaded       <= 1'b0;
                key_busy         <= 1'b1;
                byte_idx         <= '0;
                dec_key_byte_val <= 1'b1;
                dec_byte_pos     <= '0;
                dec_key_byte     <= key_in[7:0];
            end else if (state == S_LOAD) begin
                if (load_last) begin
                    key_busy         <= 1'b0;
                    key_loaded       <= 1'b1;
                    byte_idx         <= '0;
                    dec_key_byte_val <= 1'b0;
                    dec_byte_pos     <= '0;
                    dec_key_byte     <= '0;
                end else begin
                    byte_idx     <= byte_idx_inc;
                    dec_byte_pos <= byte_idx_inc;
                    dec_key_byte <= key_q[8*byte_idx_inc +: 8];
                end
            end

            // Request issue and response / timeout capture.
            if (req_go) begin
                dec_ciphertext  <= in_ct;
                dec_upper_lower <= in_upper;
                dec_ctxt_valid  <= 1'b1;
                wait_cnt        <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + TW'(1);
                if (rsp_hit) begin
                    dec_ctxt_valid <= 1'b0;
                    out_valid      <= 1'b1;
                    out_err        <= {1'b0, dec_err_ct, dec_err_key};
                    // Any error flag suppresses the plaintext, even if
                    // dec_ptxt_ready arrived in the same cycle.
                    out_pt         <= rsp_err ? 8'h00 : dec_plaintext;
                end else if (tmo_hit) begin
                    dec_ctxt_valid <= 1'b0;
                    out_valid      <= 1'b1;
                    out_err        <= 3'b100;
                    out_pt         <= 8'h00;
                end
            end

            // Result handshake; out_pt/out_err hold their value afterwards.
            if (out_fire) begin
                out_valid <= 1'b0;
                if (out_err == 3'b000) begin
                    pt_count <= pt_count + 16'd1;
                end
                if (out_err[0]) begin
                    key_loaded <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer with a small decryptor response model.
// Latency: the model answers two cycles after a request is issued (or never, in silent mode).
// Backpressure: out_ready is driven per-test, including a multi-cycle stall.
module tb_decrypt_sequencer;

    logic        clk;
    logic        rst;
    logic        key_start;
    logic [95:0] key_in;
    logic        key_busy;
    logic        key_loaded;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ct;
    logic        in_upper;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pt;
    logic [2:0]  out_err;
    logic [15:0] pt_count;
    logic [7:0]  dec_key_byte;
    logic [3:0]  dec_byte_pos;
    logic        dec_key_byte_val;
    logic        dec_ctxt_valid;
    logic [15:0] dec_ciphertext;
    logic        dec_upper_lower;
    logic [7:0]  dec_plaintext;
    logic        dec_ptxt_ready;
    logic        dec_err_key;
    logic        dec_err_ct;

    int          n_chk;
    int          n_fail;
    logic [7:0]  kb [12];

    decrypt_sequencer #(.TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .key_start        (key_start),
        .key_in           (key_in),
        .key_busy         (key_busy),
        .key_loaded       (key_loaded),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_ct            (in_ct),
        .in_upper         (in_upper),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pt           (out_pt),
        .out_err          (out_err),
        .pt_count         (pt_count),
        .dec_key_byte     (dec_key_byte),
        .dec_byte_pos     (dec_byte_pos),
        .dec_key_byte_val (dec_key_byte_val),
        .dec_ctxt_valid   (dec_ctxt_valid),
        .dec_ciphertext   (dec_ciphertext),
        .dec_upper_lower  (dec_upper_lower),
        .dec_plaintext    (dec_plaintext),
        .dec_ptxt_ready   (dec_ptxt_ready),
        .dec_err_key      (dec_err_key),
        .dec_err_ct       (dec_err_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // String literal puts the first char in the MSBs; byte k must be key char k.
    function automatic logic [95:0] pack_key(input logic [95:0] s);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 12; k++) begin
            r[8*k +: 8] = s[8*(11-k) +: 8];
        end
        return r;
    endfunction

    // Decryptor model: {key_err, ct_err, plaintext}.
    function automatic logic [9:0] model(input logic [15:0] ct, input logic up);
        logic       kerr;
        logic       cerr;
        logic [7:0] b;
        logic [7:0] c1;
        logic [7:0] c2;
        kerr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (kb[i] < "a" || kb[i] > "z") kerr = 1'b1;
            for (int j = i + 1; j < 12; j++) begin
                if (kb[i] == kb[j]) kerr = 1'b1;
            end
        end
        c1   = ct[15:8];
        c2   = ct[7:0];
        cerr = (c1 < "a") || (c1 > "z") || (c2 < "a") || (c2 > "z");
        b    = 8'h00;
        if (!cerr) begin
            if (ct == "li")      b = "h";
            else if (ct == "ae") b = "e";
            else if (ct == "lh") b = "l";
            else if (ct == "jb") b = "o";
            else if (ct == "fb") b = "w";
            else                 cerr = 1'b1;
        end
        if (up && b != 8'h00) b = b - 8'd32;
        return {kerr, cerr, b};
    endfunction

    // Called on a negedge in IDLE or READY; returns on the negedge where READY is reached.
    task automatic load_key(input logic [95:0] k);
        key_start = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_start = 1'b0;
        chk("load_clears_key_loaded", key_loaded, 0);
        for (int p = 0; p < 12; p++) begin
            chk("load_byte", {key_busy, dec_key_byte_val, dec_byte_pos, dec_key_byte},
                {1'b1, 1'b1, p[3:0], k[8*p +: 8]});
            kb[p] = dec_key_byte;
            @(negedge clk);
        end
        chk("load_done", {key_busy, dec_key_byte_val, key_loaded, in_ready}, 4'b0011);
    endtask

    // Issues one pair and plays the decryptor; returns on the negedge where out_valid is up.
    task automatic send_pair(input logic [15:0] ct, input logic up, input bit silent);
        logic [9:0] r;
        int         n;
        chk("in_ready_before_req", in_ready, 1);
        in_valid = 1'b1;
        in_ct    = ct;
        in_upper = up;
        @(negedge clk);
        in_valid = 1'b0;
        chk("req_issue", {dec_ctxt_valid, in_ready, dec_ciphertext, dec_upper_lower},
            {1'b1, 1'b0, ct, up});
        if (!silent) begin
            r = model(ct, up);
            repeat (2) @(negedge clk);
            chk("wait_holds_req", {dec_ctxt_valid, out_valid, in_ready}, 3'b100);
            dec_ptxt_ready = 1'b1;
            dec_err_key    = r[9];
            dec_err_ct     = r[8];
            dec_plaintext  = (r[9] | r[8]) ? 8'hA5 : r[7:0];
            @(negedge clk);
            dec_ptxt_ready = 1'b0;
            dec_err_key    = 1'b0;
            dec_err_ct     = 1'b0;
            dec_plaintext  = 8'h00;
            chk("rsp_taken", {out_valid, dec_ctxt_valid}, 2'b10);
        end else begin
            n = 0;
            while (!out_valid && n < 20) begin
                chk("wait_ctxt_valid_high", dec_ctxt_valid, 1);
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, 8);
            chk("timeout_drops_req", dec_ctxt_valid, 0);
        end
    endtask

    // Checks the held result, stalls, then completes the output handshake.
    task automatic take_out(input logic [7:0] exp_pt, input logic [2:0] exp_err, input int stall);
        chk("result", {out_valid, out_pt, out_err}, {1'b1, exp_pt, exp_err});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_stable", {out_valid, out_pt, out_err, in_ready}, {1'b1, exp_pt, exp_err, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drops", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        key_start      = 1'b0;
        key_in         = '0;
        in_valid       = 1'b0;
        in_ct          = '0;
        in_upper       = 1'b0;
        out_ready      = 1'b0;
        dec_plaintext  = '0;
        dec_ptxt_ready = 1'b0;
        dec_err_key    = 1'b0;
        dec_err_ct     = 1'b0;
        for (int i = 0; i < 12; i++) kb[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {key_busy, key_loaded, in_ready, out_valid, out_pt, out_err, pt_count,
            dec_key_byte, dec_byte_pos, dec_key_byte_val, dec_ctxt_valid, dec_ciphertext,
            dec_upper_lower}, 0);
        rst = 1'b0;

        // No key yet: a waiting pair is held off, not taken.
        in_valid = 1'b1;
        in_ct    = "li";
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_holds_off", {in_ready, dec_ctxt_valid, out_valid}, 3'b000);
        end
        in_valid = 1'b0;

        // "Hello"
        load_key(pack_key("abcdefghijkl"));
        send_pair("li", 1'b1, 1'b0); take_out("H", 3'b000, 0);
        send_pair("ae", 1'b0, 1'b0); take_out("e", 3'b000, 0);
        send_pair("lh", 1'b0, 1'b0); take_out("l", 3'b000, 0);
        send_pair("lh", 1'b0, 1'b0); take_out("l", 3'b000, 0);
        send_pair("jb", 1'b0, 1'b0); take_out("o", 3'b000, 0);
        chk("pt_count_hello", pt_count, 5);

        // Output stall, with a key_start during OUT that must be ignored.
        send_pair("ae", 1'b0, 1'b0);
        key_start = 1'b1;
        key_in    = pack_key("zyxwvutsrqpo");
        @(negedge clk);
        key_start = 1'b0;
        chk("key_start_ignored_in_out", {key_busy, dec_key_byte_val, key_loaded}, 3'b001);
        take_out("e", 3'b000, 5);
        chk("pt_count_after_stall", pt_count, 6);

        // Ciphertext error with simultaneous ptxt_ready.
        chk("ready_before_ct_err", in_ready, 1);
        send_pair("#@", 1'b0, 1'b0);
        take_out(8'h00, 3'b010, 0);
        chk("ct_err_keeps_key", {key_loaded, in_ready}, 2'b11);
        chk("ct_err_pt_count", pt_count, 6);

        // Silent decryptor: timeout.
        send_pair("ae", 1'b0, 1'b1);
        take_out(8'h00, 3'b100, 0);
        chk("timeout_back_ready", {key_loaded, in_ready}, 2'b11);
        chk("timeout_pt_count", pt_count, 6);

        // Reload from READY with a duplicated key byte: key error.
        load_key(pack_key("abcdefghiakl"));
        send_pair("fb", 1'b1, 1'b0);
        take_out(8'h00, 3'b001, 0);
        chk("key_err_to_idle", {key_loaded, in_ready}, 2'b00);
        chk("key_err_pt_count", pt_count, 6);
        in_valid = 1'b1;
        in_ct    = "ae";
        repeat (2) @(negedge clk);
        chk("key_err_idle_holds_off", {in_ready, dec_ctxt_valid}, 2'b00);
        in_valid = 1'b0;

        // Reset in the middle of a key load.
        key_start = 1'b1;
        key_in    = pack_key("abcdefghijkl");
        @(negedge clk);
        key_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("load_reached_pos6", {dec_key_byte_val, dec_byte_pos}, {1'b1, 4'd6});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_load_reset_outputs", {key_busy, key_loaded, in_ready, out_valid, out_pt, out_err,
            pt_count, dec_key_byte, dec_byte_pos, dec_key_byte_val, dec_ctxt_valid,
            dec_ciphertext, dec_upper_lower}, 0);
        @(negedge clk);
        chk("abandoned_load_not_loaded", {key_loaded, key_busy, dec_key_byte_val}, 3'b000);
        load_key(pack_key("abcdefghijkl"));
        send_pair("ae", 1'b0, 1'b0);
        take_out("e", 3'b000, 0);
        chk("pt_count_after_reset", pt_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
